// File: rtl/vga_frame_monitor_pkg.sv
// Shared constants, state type and signature helper
// for the VGA frame monitor.
package vga_monitor_pkg;

  localparam logic [31:0] CRC32_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] CRC32_INIT = 32'hFFFF_FFFF;

  localparam int SIG_CRC = 0;
  localparam int SIG_SUM = 1;

  localparam int CRC_MAX_W = 64;

  typedef enum logic {
    WAIT_VSYNC = 1'b0,
    RUN        = 1'b1
  } mon_state_e;

  // Shift the low `width` bits of word into acc, MSB first.
  function automatic logic [31:0] crc32_update(
    input logic [31:0]          acc,
    input logic [CRC_MAX_W-1:0] word,
    input int                   width
  );
    logic [31:0] c;
    logic        fb;
    c = acc;
    for (int i = CRC_MAX_W - 1; i >= 0; i--) begin
      if (i < width) begin
        fb = c[31] ^ word[i];
        c  = {c[30:0], 1'b0} ^ (fb ? CRC32_POLY : 32'h0);
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/vga_frame_monitor_sync_edge_detect.sv
// Registers one sync line, normalises it to "asserted"
// and pulses on its leading edge.
module sync_edge_detect #(
  parameter int ACTIVE_HIGH = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic sync_in,
  output logic edge_out
);

  localparam logic INV = (ACTIVE_HIGH == 0);

  logic sync_q;
  logic prev_q;

  // Input register plus one-cycle history for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_in ^ INV;
      prev_q <= sync_q;
    end
  end

  assign edge_out = sync_q & ~prev_q;

endmodule

// File: rtl/vga_frame_monitor.sv
// Passive VGA bus observer: timing check, per-frame
// signature, lock detection and frame counter.
module vga_frame_monitor
  import vga_monitor_pkg::*;
#(
  parameter int PIXEL_WIDTH      = 12,
  parameter int H_ACTIVE         = 640,
  parameter int H_FRONT          = 16,
  parameter int H_SYNC           = 96,
  parameter int H_BACK           = 48,
  parameter int V_ACTIVE         = 480,
  parameter int V_FRONT          = 10,
  parameter int V_SYNC           = 2,
  parameter int V_BACK           = 33,
  parameter int SYNC_ACTIVE_HIGH = 0,
  parameter int SIG_MODE         = 0
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   hsync_in,
  input  logic                   vsync_in,
  input  logic [PIXEL_WIDTH-1:0] rgb_in,
  output logic                   frame_done_out,
  output logic [31:0]            sig_out,
  output logic [15:0]            frame_count_out,
  output logic                   frame_ok_out,
  output logic                   locked_out,
  output logic                   timing_error_out
);

  localparam int H_TOTAL =
    H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL =
    V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [15:0] H_LO = 16'(H_SYNC + H_BACK);
  localparam logic [15:0] H_HI = 16'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [15:0] V_LO = 16'(V_SYNC + V_BACK);
  localparam logic [15:0] V_HI = 16'(V_SYNC + V_BACK + V_ACTIVE);

  localparam logic [16:0] H_TOT17 = 17'(H_TOTAL);
  localparam logic [16:0] V_TOT17 = 17'(V_TOTAL);

  localparam logic [31:0] WD_LAST = 32'(2 * V_TOTAL * H_TOTAL - 1);

  localparam logic [31:0] SIG_INIT =
    (SIG_MODE == SIG_CRC) ? CRC32_INIT : 32'h0;

  logic                   h_edge;
  logic                   v_edge;
  logic [PIXEL_WIDTH-1:0] rgb_q;
  logic [CRC_MAX_W-1:0]   word;

  logic [15:0] hcnt_q;
  logic [15:0] vcnt_q;
  logic [15:0] hpos;
  logic [15:0] vpos;
  logic        h_seen_q;
  logic        h_bad_q;
  logic        h_mis;
  logic        v_ok;

  logic [31:0] acc_q;
  logic [31:0] acc_upd;
  logic [31:0] wd_q;
  logic        wd_expire;
  logic        pix_active;

  mon_state_e  state_q;
  mon_state_e  state_d;
  logic        close;

  logic        close_q;
  logic        snap_ok_q;
  logic [31:0] snap_sig_q;
  logic        prev_ok_q;

  sync_edge_detect #(
    .ACTIVE_HIGH(SYNC_ACTIVE_HIGH)
  ) u_hsync (
    .clk     (clk_in),
    .rst     (rst_in),
    .sync_in (hsync_in),
    .edge_out(h_edge)
  );

  sync_edge_detect #(
    .ACTIVE_HIGH(SYNC_ACTIVE_HIGH)
  ) u_vsync (
    .clk     (clk_in),
    .rst     (rst_in),
    .sync_in (vsync_in),
    .edge_out(v_edge)
  );

  // Pixel word register, aligned with the sync registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= rgb_in;
    end
  end

  assign word = CRC_MAX_W'(rgb_q);

  // Raster position of the registered pixel, saturating.
  always_comb begin
    hpos = (hcnt_q == 16'hFFFF) ? hcnt_q : hcnt_q + 16'd1;
    if (h_edge) hpos = '0;
    vpos = vcnt_q;
    if (h_edge && vcnt_q != 16'hFFFF) vpos = vcnt_q + 16'd1;
    if (v_edge) vpos = '0;
  end

  // Geometry checks, watchdog and signature step.
  always_comb begin
    h_mis = h_edge && h_seen_q &&
            ({1'b0, hcnt_q} + 17'd1 != H_TOT17);
    v_ok  = ({1'b0, vcnt_q} + 17'd1 == V_TOT17);
    wd_expire = !v_edge && (wd_q >= WD_LAST);
    pix_active = (state_q == RUN) &&
                 (hpos >= H_LO) && (hpos < H_HI) &&
                 (vpos >= V_LO) && (vpos < V_HI);
    if (SIG_MODE == SIG_CRC) begin
      acc_upd = crc32_update(acc_q, word, PIXEL_WIDTH);
    end else begin
      acc_upd = acc_q + word[31:0];
    end
  end

  // Next state; a vsync edge in RUN closes the frame.
  always_comb begin
    state_d = state_q;
    close   = 1'b0;
    unique case (state_q)
      WAIT_VSYNC: begin
        if (v_edge) state_d = RUN;
      end
      RUN: begin
        if (wd_expire) begin
          state_d = WAIT_VSYNC;
        end else if (v_edge) begin
          close = 1'b1;
        end
      end
      default: state_d = WAIT_VSYNC;
    endcase
  end

  // State register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= WAIT_VSYNC;
    end else begin
      state_q <= state_d;
    end
  end

  // Raster counters, line-length tracking and watchdog.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      hcnt_q   <= '0;
      vcnt_q   <= '0;
      h_seen_q <= 1'b0;
      h_bad_q  <= 1'b0;
      wd_q     <= '0;
    end else begin
      hcnt_q <= hpos;
      vcnt_q <= vpos;
      if (h_edge) h_seen_q <= 1'b1;
      if (v_edge) begin
        h_bad_q <= 1'b0;
      end else if (state_q == RUN && h_mis) begin
        h_bad_q <= 1'b1;
      end
      if (v_edge) begin
        wd_q <= '0;
      end else if (wd_q != 32'hFFFF_FFFF) begin
        wd_q <= wd_q + 32'd1;
      end
    end
  end

  // Signature accumulator and frame-close snapshot.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      acc_q      <= SIG_INIT;
      close_q    <= 1'b0;
      snap_ok_q  <= 1'b0;
      snap_sig_q <= '0;
    end else begin
      if (v_edge) begin
        acc_q <= SIG_INIT;
      end else if (pix_active) begin
        acc_q <= acc_upd;
      end
      close_q <= close;
      if (close) begin
        snap_sig_q <= acc_q;
        snap_ok_q  <= !(h_bad_q || h_mis) && v_ok;
      end
    end
  end

  // Published frame status, lock and sticky error.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      frame_done_out   <= 1'b0;
      sig_out          <= '0;
      frame_count_out  <= '0;
      frame_ok_out     <= 1'b0;
      locked_out       <= 1'b0;
      timing_error_out <= 1'b0;
      prev_ok_q        <= 1'b0;
    end else begin
      frame_done_out <= close_q;
      if (close_q) begin
        sig_out         <= snap_sig_q;
        frame_ok_out    <= snap_ok_q;
        frame_count_out <= frame_count_out + 16'd1;
        prev_ok_q       <= snap_ok_q;
        if (!snap_ok_q) begin
          timing_error_out <= 1'b1;
          locked_out       <= 1'b0;
        end else if (prev_ok_q) begin
          locked_out <= 1'b1;
        end
      end
      if (wd_expire) begin
        locked_out <= 1'b0;
        prev_ok_q  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Scoreboard bench for vga_frame_monitor on a tiny
// raster: sum mode (12-bit) and CRC mode (8-bit).
module tb_vga_frame_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        hs_a, vs_a;
  logic [11:0] rgb_a;
  logic        done_a, ok_a, lk_a, te_a;
  logic [31:0] sig_a;
  logic [15:0] cnt_a;

  logic        hs_b, vs_b;
  logic [7:0]  rgb_b;
  logic        done_b, ok_b, lk_b, te_b;
  logic [31:0] sig_b;
  logic [15:0] cnt_b;

  vga_frame_monitor #(
    .PIXEL_WIDTH(12),
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(2),
    .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .SYNC_ACTIVE_HIGH(0), .SIG_MODE(1)
  ) dut_a (
    .clk_in          (clk),
    .rst_in          (rst),
    .hsync_in        (hs_a),
    .vsync_in        (vs_a),
    .rgb_in          (rgb_a),
    .frame_done_out  (done_a),
    .sig_out         (sig_a),
    .frame_count_out (cnt_a),
    .frame_ok_out    (ok_a),
    .locked_out      (lk_a),
    .timing_error_out(te_a)
  );

  vga_frame_monitor #(
    .PIXEL_WIDTH(8),
    .H_ACTIVE(1), .H_FRONT(1), .H_SYNC(1), .H_BACK(2),
    .V_ACTIVE(1), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .SYNC_ACTIVE_HIGH(0), .SIG_MODE(0)
  ) dut_b (
    .clk_in          (clk),
    .rst_in          (rst),
    .hsync_in        (hs_b),
    .vsync_in        (vs_b),
    .rgb_in          (rgb_b),
    .frame_done_out  (done_b),
    .sig_out         (sig_b),
    .frame_count_out (cnt_b),
    .frame_ok_out    (ok_b),
    .locked_out      (lk_b),
    .timing_error_out(te_b)
  );

  typedef struct {
    logic [31:0] sig;
    logic        ok;
    logic [15:0] cnt;
    logic        lk;
    logic        te;
    int          cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  // Reference CRC-32/MPEG-2, byte at a time.
  function automatic logic [31:0] crc_mpeg2(
    input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {b, 24'h0};
    for (int i = 0; i < 8; i++)
      r = r[31] ? ((r << 1) ^ 32'h04C11DB7) : (r << 1);
    return r;
  endfunction

  // Frame model for dut_a.
  bit ma_run, ma_ok, ma_prev, ma_lk, ma_te;
  int ma_sum, ma_cnt;

  task automatic close_a();
    exp_t e;
    if (ma_run) begin
      ma_cnt++;
      if (!ma_ok) begin
        ma_lk = 0;
        ma_te = 1;
      end else if (ma_prev) begin
        ma_lk = 1;
      end
      ma_prev = ma_ok;
      e.sig = 32'(ma_sum);
      e.ok  = ma_ok;
      e.cnt = 16'(ma_cnt);
      e.lk  = ma_lk;
      e.te  = ma_te;
      e.cyc = cyc + 3;
      qa.push_back(e);
    end
    ma_run = 1;
    ma_sum = 0;
    ma_ok  = 1;
  endtask

  task automatic reset_model_a();
    ma_run = 0; ma_ok = 0; ma_prev = 0;
    ma_lk = 0; ma_te = 0; ma_sum = 0; ma_cnt = 0;
  endtask

  // One 8-clock-per-line frame; pat 0 = ones, 1 = ramp.
  task automatic gen_a(input int pat, input int stretch,
                       input int nlines, input bit vs_en);
    int k;
    int len;
    bit act;
    logic [11:0] px;
    k = 0;
    for (int y = 0; y < nlines; y++) begin
      len = (y == stretch) ? 9 : 8;
      for (int x = 0; x < len; x++) begin
        @(negedge clk);
        if (vs_en && y == 0 && x == 0) close_a();
        if (y == stretch && x == 0) ma_ok = 0;
        act = (x >= 3 && x < 7 && y >= 2 && y < 5);
        px = 12'hA5A;
        if (act) begin
          px = (pat != 0) ? 12'(k) : 12'd1;
          k++;
          ma_sum += int'(px);
        end
        hs_a  = (x == 0) ? 1'b0 : 1'b1;
        vs_a  = (vs_en && y == 0) ? 1'b0 : 1'b1;
        rgb_a = px;
      end
    end
  endtask

  // Frame model for dut_b.
  bit mb_run, mb_prev, mb_lk;
  int mb_cnt;

  task automatic gen_b();
    exp_t e;
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 5; x++) begin
        @(negedge clk);
        if (y == 0 && x == 0) begin
          if (mb_run) begin
            mb_cnt++;
            if (mb_prev) mb_lk = 1;
            mb_prev = 1;
            e.sig = crc_mpeg2(32'hFFFFFFFF, 8'h00);
            e.ok  = 1'b1;
            e.cnt = 16'(mb_cnt);
            e.lk  = mb_lk;
            e.te  = 1'b0;
            e.cyc = cyc + 3;
            qb.push_back(e);
          end
          mb_run = 1;
        end
        hs_b  = (x == 0) ? 1'b0 : 1'b1;
        vs_b  = (y == 0) ? 1'b0 : 1'b1;
        rgb_b = 8'h00;
      end
    end
  endtask

  task automatic chk_zero_a(input string tag);
    chk({tag, "_done"}, 32'(done_a), 32'd0);
    chk({tag, "_sig"},  sig_a,       32'd0);
    chk({tag, "_cnt"},  32'(cnt_a),  32'd0);
    chk({tag, "_ok"},   32'(ok_a),   32'd0);
    chk({tag, "_lk"},   32'(lk_a),   32'd0);
    chk({tag, "_te"},   32'(te_a),   32'd0);
  endtask

  // Monitors: pop and compare on every frame_done.
  always @(negedge clk) begin
    if (done_a) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected_done cyc=%0d", cyc);
      end else begin
        ea = qa.pop_front();
        chk("a_sig", sig_a, ea.sig);
        chk("a_ok",  32'(ok_a), 32'(ea.ok));
        chk("a_cnt", 32'(cnt_a), 32'(ea.cnt));
        chk("a_lock", 32'(lk_a), 32'(ea.lk));
        chk("a_terr", 32'(te_a), 32'(ea.te));
        chk("a_latency", 32'(cyc), 32'(ea.cyc));
      end
    end
    if (done_b) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_done cyc=%0d", cyc);
      end else begin
        eb = qb.pop_front();
        chk("b_sig", sig_b, eb.sig);
        chk("b_ok",  32'(ok_b), 32'(eb.ok));
        chk("b_cnt", 32'(cnt_b), 32'(eb.cnt));
        chk("b_lock", 32'(lk_b), 32'(eb.lk));
        chk("b_terr", 32'(te_b), 32'(eb.te));
        chk("b_latency", 32'(cyc), 32'(eb.cyc));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    hs_a = 1'b1; vs_a = 1'b1; rgb_a = '0;
    hs_b = 1'b1; vs_b = 1'b1; rgb_b = '0;
    reset_model_a();
    mb_run = 0; mb_prev = 0; mb_lk = 0; mb_cnt = 0;
    repeat (3) @(negedge clk);
    chk_zero_a("reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Ideal frames with rgb=1: sig 12, lock on pulse 2.
    repeat (4) gen_a(0, -1, 6, 1);
    // Ramp frame (sig 66), then a frame with a 9-clock line.
    gen_a(1, -1, 6, 1);
    gen_a(0, -1, 6, 1);
    gen_a(0, 3, 6, 1);
    repeat (3) gen_a(0, -1, 6, 1);
    chk("locked_before_wd", 32'(lk_a), 32'd1);

    // Vsync stops: 13 lines = 104 clocks > 2*6*8.
    gen_a(0, -1, 13, 0);
    chk("locked_after_wd", 32'(lk_a), 32'd0);
    chk("terr_after_wd", 32'(te_a), 32'd1);
    ma_run = 0; ma_prev = 0; ma_lk = 0;
    repeat (4) gen_a(0, -1, 6, 1);
    chk("relocked", 32'(lk_a), 32'd1);

    // Reset in the middle of a frame.
    gen_a(0, -1, 3, 1);
    chk("cnt_before_rst_nonzero", 32'(cnt_a != 16'd0), 32'd1);
    @(negedge clk);
    hs_a = 1'b1; vs_a = 1'b1;
    #2 rst = 1'b1;
    #1 chk_zero_a("midrst");
    chk("queue_a_at_rst", 32'(qa.size()), 32'd0);
    reset_model_a();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) gen_a(0, -1, 6, 1);
    repeat (4) @(negedge clk);

    // CRC mode: single active byte 0x00 per frame.
    repeat (3) gen_b();
    repeat (6) @(negedge clk);

    chk("queue_a_drained", 32'(qa.size()), 32'd0);
    chk("queue_b_drained", 32'(qb.size()), 32'd0);
    chk("final_cnt_a", 32'(cnt_a), 32'd2);
    chk("final_cnt_b", 32'(cnt_b), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
